jk_seq_driver: RTL and testbench
================================

# jk_seq_driver

Self-checking stimulus driver for the JK flip-flop: the other end of the `jk_ff` j/k/q interface. It accepts a target bit pattern and computes, from the observed `q`, the J/K excitation needed to make `q` follow the pattern, one bit per step. It drives `j`/`k` into the flop, reads `q` back, and counts mismatches. It sits beside `jk_ff` on the same clock and replaces hand-written j/k stimulus in flop-level benches and bring-up.

## Interface
- `LEN`, 8: pattern length in bits; legal range 1..32.
- `CW`, 8: width of the error counter.

- `clk`  in  1  rising-edge clock, shared with `jk_ff`.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request to begin a run; sampled only in IDLE.
- `pattern`  in  LEN  target `q` sequence, LSB first; captured on the accepted `start` edge.
- `q`  in  1  observed output of `jk_ff`.
- `j`  out  1  J excitation to `jk_ff`, registered.
- `k`  out  1  K excitation to `jk_ff`, registered.
- `busy`  out  1  high from the accepted `start` until DONE.
- `done`  out  1  one-cycle pulse when a run completes.
- `err_cnt`  out  CW  count of mismatches in the current or last run; saturates at 2^CW-1.
- `pass`  out  1  high after a completed run with `err_cnt`==0; held until the next accepted `start` or reset.

## Operation
- FSM states: IDLE, DRIVE, APPLY, CHECK, DONE. Bit index `idx` has width clog2(LEN), minimum 1.
- IDLE:
  - `j`=`k`=0.
  - `start`=1 captures `pattern`, clears `idx`, `err_cnt` and `pass`, sets `busy`, and moves to DRIVE.
- DRIVE: registers `j`,`k` from target t=`pattern[idx]` and the current `q`, then moves to APPLY.
  - Bit 0 always uses the forced form `j`=t, `k`=~t. This defines `q` even if the flop starts unknown.
  - Bits 1..LEN-1 with `q`==t: `j`=`k`=0 (hold).
  - Bits 1..LEN-1 with `q`!=t: the form depends on the macro (see Configuration).
- APPLY:
  - The flop samples `j`/`k` on this edge.
  - The driver returns `j`=`k`=0 on the same edge and moves to CHECK.
- CHECK:
  - Compares `q` with t. On mismatch, increments `err_cnt`, saturating.
  - If `idx`==LEN-1, moves to DONE; otherwise increments `idx` and moves to DRIVE.
- DONE:
  - Asserts `done` for this one cycle, clears `busy`, sets `pass`=(`err_cnt`==0).
  - Moves to IDLE unconditionally.
- `start` is ignored outside IDLE. If `start` is held high through DONE, a new run starts from IDLE on the next edge.
- Reset, including mid-run: state IDLE; `j`=`k`=`busy`=`done`=`pass`=0; `err_cnt`=0; `idx`=0. The captured pattern is don't-care.

## Timing
- Three cycles per bit. Let E0 be the edge on which `start` is accepted.
- Bit i:
  - DRIVE edge at E0+1+3i.
  - Flop capture at E0+2+3i.
  - Compare at E0+3+3i.
- The last compare is at E0+3·LEN. `err_cnt` is final after that edge.
- `done`=1 and `pass` become valid in the cycle following E0+3·LEN. `done` falls at E0+3·LEN+1.
- Earliest next accepted `start` is at E0+3·LEN+2.
- `j`/`k` are non-zero only in the single cycle after a DRIVE edge.

## Configuration
- `JK_TOGGLE_EN` defined: for bits 1..LEN-1 with `q`!=t, drive `j`=`k`=1 (toggle). This exercises the flop's toggle path.
- `JK_TOGGLE_EN` undefined: for bits 1..LEN-1 with `q`!=t, drive `j`=t, `k`=~t (set/reset). Toggle is never emitted.
- Bit 0 and hold behaviour are identical in both builds.

## Test plan
- Connected to `jk_ff`, LEN=8, `pattern`=8'hAA, `start` at E0 → `done` pulse after E0+24, `err_cnt`=0, `pass`=1, `q` sequence 0,1,0,1,0,1,0,1.
- Macro undefined, `pattern`=8'h55 → bit 0 drives `j`=1,`k`=0; each later bit drives set/reset alternately; `j`&`k` is never 1; `pass`=1.
- `JK_TOGGLE_EN` defined, `pattern`=8'h55 → bits 1..7 each drive `j`=`k`=1; `pass`=1.
- `pattern`=8'hFF → bits 1..7 drive `j`=`k`=0 (hold); `q` stays 1; `pass`=1.
- `q` tied to 0 instead of the flop, `pattern`=8'hF0 → `err_cnt`=4, `pass`=0.
- `rst` pulsed during CHECK of bit 3 → all outputs 0 immediately.
  - A new `start` with 8'h0F then completes in 24 cycles with `pass`=1.
  - A `start` pulsed while `busy`=1 has no effect.

Source files
------------

// File: rtl/jk_seq_driver.sv
// Stimulus driver for a JK flop: drives J/K so q follows a captured pattern, then counts mismatches.
// Build option: define JK_TOGGLE_EN to correct mismatches on bits 1..LEN-1 with a toggle (J=K=1).
module jk_seq_driver #(
  parameter int LEN = 8,
  parameter int CW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] pattern,
  input  logic           q,
  output logic           j,
  output logic           k,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  err_cnt,
  output logic           pass
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_APPLY = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           j_q, j_d;
  logic           k_q, k_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [CW-1:0]  err_q, err_d;

  logic           tgt_s;
  logic           last_s;

  assign tgt_s  = pat_q[idx_q];
  assign last_s = (idx_q == IW'(LEN - 1));

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; J/K and done default to 0 so they are non-zero for one cycle only
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          idx_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DRIVE: begin
        // Bit 0 is always forced so q is defined even from an unknown flop state
        if (idx_q == '0) begin
          j_d = tgt_s;
          k_d = ~tgt_s;
        end else if (q == tgt_s) begin
          j_d = 1'b0;
          k_d = 1'b0;
        end else begin
`ifdef JK_TOGGLE_EN
          j_d = 1'b1;
          k_d = 1'b1;
`else
          j_d = tgt_s;
          k_d = ~tgt_s;
`endif
        end
        state_d = S_APPLY;
      end

      S_APPLY: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if ((q != tgt_s) && (err_q != {CW{1'b1}})) begin
          err_d = err_q + CW'(1);
        end else begin
          err_d = err_q;
        end
        if (last_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign j       = j_q;
  assign k       = k_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: behavioural JK flop plus an edge-count reference model of the driver.
module tb_jk_seq_driver;
  localparam int LEN = 8;
  localparam int CW  = 8;
  localparam int ERR_MAX = (1 << CW) - 1;
`ifdef JK_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [LEN-1:0] pattern;
  logic           q_ff = 1'b0;
  logic           tie0;
  logic           scramble;
  logic           q_src;
  logic           j, k, busy, done, pass;
  logic [CW-1:0]  err_cnt;

  jk_seq_driver #(.LEN(LEN), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .q(q_src),
    .j(j), .k(k), .busy(busy), .done(done), .err_cnt(err_cnt), .pass(pass)
  );

  always #5 clk = ~clk;

  assign q_src = tie0 ? 1'b0 : q_ff;

  // JK flop under test; scramble gives it an arbitrary start value between runs
  always @(posedge clk) begin
    if (scramble) q_ff <= 1'($urandom);
    else begin
      case ({j, k})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // reference model: edges counted from the accepted start
  bit             m_run = 1'b0;
  int             m_n = 0;
  logic [LEN-1:0] m_pat = '0;
  int             m_err = 0;
  bit             m_pass = 1'b0;
  bit             e_j = 1'b0, e_k = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  bit             q_last = 1'b0;
  logic [LEN-1:0] q_seen = '0;
  int             jk11_cnt = 0, jkany_cnt = 0;

  task chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task model_step();
    int i, ph;
    bit t;
    if (rst) begin
      m_run = 1'b0; m_err = 0; m_pass = 1'b0;
      e_j = 1'b0; e_k = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else if (!m_run) begin
      e_j = 1'b0; e_k = 1'b0; e_done = 1'b0;
      if (start) begin
        m_run = 1'b1; m_n = 0; m_pat = pattern; m_err = 0; m_pass = 1'b0;
        e_busy = 1'b1; q_seen = '0; jk11_cnt = 0; jkany_cnt = 0;
      end
    end else begin
      m_n++;
      e_j = 1'b0; e_k = 1'b0; e_done = 1'b0;
      if (m_n <= 3 * LEN) begin
        i  = (m_n - 1) / 3;
        ph = (m_n - 1) % 3;
        t  = m_pat[i];
        if (ph == 0) begin
          if (i == 0)           begin e_j = t;    e_k = !t;   end
          else if (q_last == t) begin e_j = 1'b0; e_k = 1'b0; end
          else if (TOG)         begin e_j = 1'b1; e_k = 1'b1; end
          else                  begin e_j = t;    e_k = !t;   end
        end else if (ph == 2) begin
          q_seen[i] = q_last;
          if (q_last != t && m_err < ERR_MAX) m_err++;
          if (m_n == 3 * LEN) begin
            e_busy = 1'b0; e_done = 1'b1; m_pass = (m_err == 0);
          end
        end
      end else begin
        m_run = 1'b0;
      end
    end
  endtask

  // one clock: sample on the falling edge, advance model, compare, then allow new inputs
  task tick();
    @(negedge clk);
    model_step();
    if (m_run && !rst) begin
      if (j & k) jk11_cnt++;
      if (j | k) jkany_cnt++;
    end
    if (chk_en) begin
      chk("j", 32'(j), 32'(e_j));
      chk("k", 32'(k), 32'(e_k));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err_cnt", 32'(err_cnt), m_err);
      chk("pass", 32'(pass), 32'(m_pass));
    end
    q_last = q_src;
    #1;
  endtask

  task run_pat(input logic [LEN-1:0] p, input bit tie, input bit noisy);
    scramble = 1'b1;
    tick();
    scramble = 1'b0;
    tie0 = tie; pattern = p; start = 1'b1;
    tick();
    start = 1'b0;
    pattern = LEN'($urandom);
    for (int c = 0; c < 3 * LEN + 6 && m_run; c++) begin
      tick();
      start = noisy && m_run && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    if (m_run) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: run still active, expected done within %0d cycles", 3 * LEN + 6);
      m_run = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; tie0 = 1'b0; scramble = 1'b0;
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pass", 32'(pass), 0);

    run_pat(8'hAA, 1'b0, 1'b0);
    chk("aa_err", 32'(err_cnt), 0);
    chk("aa_pass", 32'(pass), 1);
    chk("aa_qseq", 32'(q_seen), 32'h0000_00AA);

    run_pat(8'h55, 1'b0, 1'b0);
    chk("55_jk11", jk11_cnt, TOG ? 7 : 0);
    chk("55_jkany", jkany_cnt, 8);
    chk("55_pass", 32'(pass), 1);

    run_pat(8'hFF, 1'b0, 1'b0);
    chk("ff_jkany", jkany_cnt, 1);
    chk("ff_qseq", 32'(q_seen), 32'h0000_00FF);
    chk("ff_pass", 32'(pass), 1);

    run_pat(8'hF0, 1'b1, 1'b0);
    chk("f0tie_err", 32'(err_cnt), 4);
    chk("f0tie_pass", 32'(pass), 0);

    // reset during CHECK of bit 3, with errors already counted
    scramble = 1'b0; tie0 = 1'b1; pattern = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && m_run && m_n < 11; c++) tick();
    chk("pre_rst_err", 32'(err_cnt), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_j", 32'(j), 0);
    chk("mid_rst_k", 32'(k), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_err", 32'(err_cnt), 0);
    chk("mid_rst_pass", 32'(pass), 0);
    tick();
    rst = 1'b0;
    tick();

    run_pat(8'h0F, 1'b0, 1'b1);
    chk("0f_err", 32'(err_cnt), 0);
    chk("0f_pass", 32'(pass), 1);
    chk("0f_qseq", 32'(q_seen), 32'h0000_000F);

    for (int r = 0; r < 14; r++) begin
      run_pat(LEN'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
